// File: rtl/fetch_unit.sv
// ============================================================================
// Module   : fetch_unit
// Purpose  : Instruction fetch stage for the single-issue MIPS core. Holds
//            the PC and fetches one word at a time from instruction memory
//            over a request/grant/response handshake. It presents the
//            fetched word to the decoder with a valid/ready handshake. When
//            the word is accepted it loads the next PC from the decoder's
//            jump/jr controls and the execute stage's branch resolution.
//
// Ports    : clk, rst_n          - clock, asynchronous active-low reset
//            imem_req/addr       - registered fetch request, address (= pc)
//            imem_gnt            - memory accepted the request
//            imem_rvalid/rdata   - instruction response
//            inst/inst_valid     - latched instruction to the decoder
//            inst_ready          - decoder accepts inst
//            pc/pc_plus4         - address of inst and its link value
//            jump/jr/jr_target   - decoder redirect controls
//            branch_taken        - resolved branch outcome from execute
//            fault               - misaligned-target fault
//
// Config   : `define FETCH_ALIGN_CHECK_EN to trap misaligned next-PC values.
//            A trapped value parks the FSM in HALT with fault=1 until reset.
//            When the macro is left undefined, bits [1:0] of the next PC are
//            cleared, fault is tied low, and HALT is never entered.
//
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module fetch_unit #(
    parameter int                    ADDR_WIDTH = 32,
    // Must be word aligned.
    parameter logic [ADDR_WIDTH-1:0] RESET_PC   = 32'h0000_0000
) (
    input  logic                  clk,
    input  logic                  rst_n,

    // Instruction memory port
    output logic                  imem_req,
    output logic [ADDR_WIDTH-1:0] imem_addr,
    input  logic                  imem_gnt,
    input  logic                  imem_rvalid,
    input  logic [31:0]           imem_rdata,

    // Decoder-facing instruction port
    output logic [31:0]           inst,
    output logic                  inst_valid,
    input  logic                  inst_ready,
    output logic [ADDR_WIDTH-1:0] pc,
    output logic [ADDR_WIDTH-1:0] pc_plus4,

    // Redirect controls, sampled on the accepting edge
    input  logic [1:0]            jump,
    input  logic                  jr,
    input  logic [ADDR_WIDTH-1:0] jr_target,
    input  logic                  branch_taken,

    output logic                  fault
);

    // ------------------------------------------------------------------------
    // State encoding
    // ------------------------------------------------------------------------
    localparam logic [2:0] c_ST_IDLE  = 3'd0;
    localparam logic [2:0] c_ST_FETCH = 3'd1;
    localparam logic [2:0] c_ST_WAIT  = 3'd2;
    localparam logic [2:0] c_ST_ISSUE = 3'd3;
    localparam logic [2:0] c_ST_HALT  = 3'd4;

    localparam logic [1:0] c_JUMP_J   = 2'b01;
    localparam logic [1:0] c_JUMP_JAL = 2'b10;

    localparam logic [ADDR_WIDTH-1:0] c_WORD_STEP  = ADDR_WIDTH'(4);
    localparam logic [ADDR_WIDTH-1:0] c_ALIGN_MASK = ADDR_WIDTH'(3);

    // ------------------------------------------------------------------------
    // Registers
    // ------------------------------------------------------------------------
    logic [2:0]            r_state;
    logic [ADDR_WIDTH-1:0] r_pc;
    logic                  r_req;
    logic [31:0]           r_inst;
    logic                  r_valid;
    logic                  r_fault;

    // ------------------------------------------------------------------------
    // Next-PC datapath
    // ------------------------------------------------------------------------
    logic [ADDR_WIDTH-1:0] w_pc_plus4;
    logic [ADDR_WIDTH-1:0] w_jump_target;
    logic [ADDR_WIDTH-1:0] w_branch_offset;
    logic [ADDR_WIDTH-1:0] w_branch_target;
    logic                  w_is_jump;
    logic [ADDR_WIDTH-1:0] w_next_raw;
    logic [ADDR_WIDTH-1:0] w_next_pc;
    logic                  w_accept;

    // All address arithmetic wraps modulo 2^ADDR_WIDTH by construction.
    assign w_pc_plus4 = r_pc + c_WORD_STEP;

    // The region bits come from pc+4 rather than pc. This matters only for
    // an instruction that sits in the last word of a 256 MB region.
    assign w_jump_target = {w_pc_plus4[ADDR_WIDTH-1:28], r_inst[25:0], 2'b00};

    // The 16-bit word offset is sign-extended and scaled to a byte offset.
    assign w_branch_offset = {{(ADDR_WIDTH-18){r_inst[15]}}, r_inst[15:0], 2'b00};
    assign w_branch_target = w_pc_plus4 + w_branch_offset;

    // The reserved code 11 is treated the same as "no jump".
    assign w_is_jump = (jump == c_JUMP_J) || (jump == c_JUMP_JAL);

    // Redirect priority: jr > j/jal > taken branch > sequential.
    always_comb begin
        w_next_raw = w_pc_plus4;
        if (jr) begin
            w_next_raw = jr_target;
        end else if (w_is_jump) begin
            w_next_raw = w_jump_target;
        end else if (branch_taken) begin
            w_next_raw = w_branch_target;
        end
    end

    assign w_accept = (r_state == c_ST_ISSUE) && inst_ready;

`ifdef FETCH_ALIGN_CHECK_EN
    // Only jr can produce a misaligned target, because pc itself is always
    // aligned. The check is done on the raw value so it covers every source.
    logic w_misaligned;
    assign w_misaligned = |(w_next_raw & c_ALIGN_MASK);
    assign w_next_pc    = w_next_raw;
`else
    logic w_misaligned;
    assign w_misaligned = 1'b0;
    // Silently word-align the target.
    assign w_next_pc    = w_next_raw & ~c_ALIGN_MASK;
`endif

    // ------------------------------------------------------------------------
    // Control FSM with registered outputs.
    // imem_req and inst_valid are set on the transition into the state that
    // owns them, so each output lines up with its state without a
    // combinational decode.
    // ------------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= c_ST_IDLE;
            r_pc    <= RESET_PC;
            r_req   <= 1'b0;
            r_inst  <= 32'h0000_0000;
            r_valid <= 1'b0;
            r_fault <= 1'b0;
        end else begin
            case (r_state)
                c_ST_IDLE: begin
                    // A late response left over from before reset is dropped
                    // here and in FETCH, because only WAIT looks at rvalid.
                    r_state <= c_ST_FETCH;
                    r_req   <= 1'b1;
                end

                c_ST_FETCH: begin
                    // imem_addr follows r_pc, which is held here, so the
                    // address stays stable until the grant arrives.
                    if (imem_gnt) begin
                        r_state <= c_ST_WAIT;
                        r_req   <= 1'b0;
                    end
                end

                c_ST_WAIT: begin
                    if (imem_rvalid) begin
                        r_inst  <= imem_rdata;
                        r_valid <= 1'b1;
                        r_state <= c_ST_ISSUE;
                    end
                end

                c_ST_ISSUE: begin
                    if (w_accept) begin
                        r_valid <= 1'b0;
                        if (w_misaligned) begin
                            // Keep the faulting PC visible for debug.
                            r_state <= c_ST_HALT;
                            r_fault <= 1'b1;
                        end else begin
                            r_pc    <= w_next_pc;
                            r_state <= c_ST_FETCH;
                            r_req   <= 1'b1;
                        end
                    end
                end

                c_ST_HALT: begin
                    // Only reset leaves HALT.
                    r_req   <= 1'b0;
                    r_valid <= 1'b0;
                end

                default: begin
                    // Unused encodings restart the fetch sequence cleanly.
                    r_state <= c_ST_IDLE;
                    r_req   <= 1'b0;
                    r_valid <= 1'b0;
                end
            endcase
        end
    end

    // ------------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------------
    assign imem_req   = r_req;
    assign imem_addr  = r_pc;
    assign inst       = r_inst;
    assign inst_valid = r_valid;
    assign pc         = r_pc;
    assign pc_plus4   = w_pc_plus4;

`ifdef FETCH_ALIGN_CHECK_EN
    assign fault = r_fault;
`else
    // r_fault never leaves zero in this build. It is still routed to the
    // output so that the register keeps a load.
    assign fault = r_fault;
`endif

endmodule

`default_nettype wire

// File: tb/tb_fetch_unit.sv
// ============================================================================
// Module   : tb_fetch_unit
// Purpose  : Directed, table-driven bench for fetch_unit. The bench acts as
//            the instruction memory and the decoder. It walks a chain of
//            vectors, where each vector's expected next PC is the fetch
//            address of the vector that follows it. It then runs hand-written
//            sequences for the misaligned jr target and for a reset asserted
//            while a request is outstanding.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_fetch_unit;

    localparam logic [31:0] c_RESET_PC = 32'h0000_0100;
    localparam logic [31:0] c_JUNK     = 32'hDEAD_BEEF;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_gnt;
    logic        imem_rvalid;
    logic [31:0] imem_rdata;
    logic [31:0] inst;
    logic        inst_valid;
    logic        inst_ready;
    logic [31:0] pc;
    logic [31:0] pc_plus4;
    logic [1:0]  jump;
    logic        jr;
    logic [31:0] jr_target;
    logic        branch_taken;
    logic        fault;

    always #5 clk = ~clk;

    fetch_unit #(
        .ADDR_WIDTH (32),
        .RESET_PC   (c_RESET_PC)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .imem_req     (imem_req),
        .imem_addr    (imem_addr),
        .imem_gnt     (imem_gnt),
        .imem_rvalid  (imem_rvalid),
        .imem_rdata   (imem_rdata),
        .inst         (inst),
        .inst_valid   (inst_valid),
        .inst_ready   (inst_ready),
        .pc           (pc),
        .pc_plus4     (pc_plus4),
        .jump         (jump),
        .jr           (jr),
        .jr_target    (jr_target),
        .branch_taken (branch_taken),
        .fault        (fault)
    );

    typedef struct {
        logic [31:0] word;      // instruction returned by memory
        logic        jr;
        logic [1:0]  jump;
        logic [31:0] tgt;       // jr_target
        logic        br;        // branch_taken
        int          gnt_wait;  // FETCH cycles before grant
        int          rv_wait;   // WAIT cycles before rvalid
        int          hold;      // ISSUE cycles with inst_ready low
        logic [31:0] exp_pc;    // expected fetch address / pc in ISSUE
        logic [31:0] exp_pc4;   // expected pc_plus4 in ISSUE
        logic [31:0] exp_next;  // expected imem_addr after acceptance
    } vec_t;

    vec_t vecs[16];

    int n_vec = 0;
    int n_err = 0;

    function automatic vec_t mk(input logic [31:0] word, input logic jr_i,
                                input logic [1:0] jump_i, input logic [31:0] tgt,
                                input logic br, input int gw, input int rw,
                                input int hold, input logic [31:0] epc,
                                input logic [31:0] epc4, input logic [31:0] enext);
        vec_t v;
        v.word = word;   v.jr = jr_i;      v.jump = jump_i;   v.tgt = tgt;
        v.br = br;       v.gnt_wait = gw;  v.rv_wait = rw;    v.hold = hold;
        v.exp_pc = epc;  v.exp_pc4 = epc4; v.exp_next = enext;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %08h, expected %08h", name, act, exp);
        end
    endtask

    task automatic clear_redirect();
        jr = 1'b0; jump = 2'b00; jr_target = 32'h0; branch_taken = 1'b0;
    endtask

    // Runs FETCH and WAIT from a negedge in FETCH, and ends at the first
    // negedge of ISSUE.
    task automatic do_fetch(input string tag, input logic [31:0] exp_addr,
                            input logic [31:0] word, input int gnt_wait,
                            input int rv_wait);
        int t = 0;
        while (imem_req !== 1'b1 && t < 20) begin
            @(negedge clk);
            t++;
        end
        chk({tag, " req"}, 32'(imem_req), 32'd1);
        chk({tag, " addr"}, imem_addr, exp_addr);
        for (int i = 0; i < gnt_wait; i++) begin
            // A stray response in FETCH must be ignored.
            imem_rvalid = 1'b1;
            imem_rdata  = c_JUNK;
            @(negedge clk);
            chk({tag, " addr hold"}, imem_addr, exp_addr);
        end
        imem_rvalid = 1'b0;
        imem_gnt    = 1'b1;
        @(negedge clk);
        imem_gnt = 1'b0;
        chk({tag, " req drop"}, 32'(imem_req), 32'd0);
        for (int i = 0; i < rv_wait; i++) begin
            @(negedge clk);
            chk({tag, " wait valid"}, 32'(inst_valid), 32'd0);
        end
        imem_rvalid = 1'b1;
        imem_rdata  = word;
        @(negedge clk);
        imem_rvalid = 1'b0;
        imem_rdata  = c_JUNK;
        chk({tag, " valid"}, 32'(inst_valid), 32'd1);
        chk({tag, " inst"}, inst, word);
    endtask

    // Runs from the first negedge of ISSUE, and ends at the negedge after
    // the accepting edge.
    task automatic do_accept(input string tag, input vec_t v);
        chk({tag, " pc"}, pc, v.exp_pc);
        chk({tag, " pc4"}, pc_plus4, v.exp_pc4);
        for (int i = 0; i < v.hold; i++) begin
            inst_ready  = 1'b0;
            imem_rvalid = 1'b1;   // must not disturb the latched word
            @(negedge clk);
            chk({tag, " hold valid"}, 32'(inst_valid), 32'd1);
            chk({tag, " hold inst"}, inst, v.word);
            chk({tag, " hold pc"}, pc, v.exp_pc);
            chk({tag, " hold req"}, 32'(imem_req), 32'd0);
        end
        imem_rvalid  = 1'b0;
        jr           = v.jr;
        jump         = v.jump;
        jr_target    = v.tgt;
        branch_taken = v.br;
        inst_ready   = 1'b1;
        @(negedge clk);
        inst_ready = 1'b0;
        clear_redirect();
        chk({tag, " valid drop"}, 32'(inst_valid), 32'd0);
        chk({tag, " next"}, imem_addr, v.exp_next);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        // Chain of vectors. Each exp_next equals the exp_pc of the next row.
        //           word          jr    jump   jr_tgt        br   gw rw hd  pc            pc+4          next
        vecs[0]  = mk(32'h0000_0000, 1'b0, 2'b00, 32'h0,        1'b0, 0, 0, 0, 32'h0000_0100, 32'h0000_0104, 32'h0000_0104);
        vecs[1]  = mk(32'h2108_0001, 1'b0, 2'b00, 32'h0,        1'b0, 0, 0, 5, 32'h0000_0104, 32'h0000_0108, 32'h0000_0108);
        vecs[2]  = mk(32'h0800_0010, 1'b0, 2'b01, 32'h0,        1'b0, 0, 0, 0, 32'h0000_0108, 32'h0000_010C, 32'h0000_0040);
        vecs[3]  = mk(32'h0C00_0050, 1'b0, 2'b11, 32'h0,        1'b0, 2, 1, 0, 32'h0000_0040, 32'h0000_0044, 32'h0000_0044);
        vecs[4]  = mk(32'h03E0_0008, 1'b1, 2'b00, 32'h1000_0040, 1'b0, 0, 0, 0, 32'h0000_0044, 32'h0000_0048, 32'h1000_0040);
        vecs[5]  = mk(32'h0C00_0010, 1'b0, 2'b10, 32'h0,        1'b0, 0, 0, 0, 32'h1000_0040, 32'h1000_0044, 32'h1000_0040);
        vecs[6]  = mk(32'h03E0_0008, 1'b1, 2'b00, 32'h0000_0200, 1'b0, 1, 0, 0, 32'h1000_0040, 32'h1000_0044, 32'h0000_0200);
        vecs[7]  = mk(32'h1000_FFFE, 1'b0, 2'b00, 32'h0,        1'b1, 0, 3, 0, 32'h0000_0200, 32'h0000_0204, 32'h0000_01FC);
        vecs[8]  = mk(32'h1000_FFFE, 1'b1, 2'b00, 32'h0000_0080, 1'b1, 0, 0, 0, 32'h0000_01FC, 32'h0000_0200, 32'h0000_0080);
        vecs[9]  = mk(32'h1000_0003, 1'b0, 2'b00, 32'h0,        1'b1, 0, 0, 0, 32'h0000_0080, 32'h0000_0084, 32'h0000_0090);
        vecs[10] = mk(32'h0800_0100, 1'b0, 2'b01, 32'h0,        1'b1, 0, 0, 0, 32'h0000_0090, 32'h0000_0094, 32'h0000_0400);
        vecs[11] = mk(32'h03E0_0008, 1'b1, 2'b00, 32'hFFFF_FFFC, 1'b0, 0, 0, 0, 32'h0000_0400, 32'h0000_0404, 32'hFFFF_FFFC);
        vecs[12] = mk(32'h0000_0000, 1'b0, 2'b00, 32'h0,        1'b0, 0, 0, 0, 32'hFFFF_FFFC, 32'h0000_0000, 32'h0000_0000);
        vecs[13] = mk(32'h0800_0001, 1'b0, 2'b01, 32'h0,        1'b0, 0, 0, 0, 32'h0000_0000, 32'h0000_0004, 32'h0000_0004);
        vecs[14] = mk(32'h1000_8000, 1'b0, 2'b00, 32'h0,        1'b1, 0, 0, 0, 32'h0000_0004, 32'h0000_0008, 32'hFFFE_0008);
        vecs[15] = mk(32'h03E0_0008, 1'b1, 2'b00, 32'h0000_0100, 1'b0, 0, 0, 0, 32'hFFFE_0008, 32'hFFFE_000C, 32'h0000_0100);

        rst_n       = 1'b0;
        imem_gnt    = 1'b0;
        imem_rvalid = 1'b0;
        imem_rdata  = 32'h0;
        inst_ready  = 1'b0;
        clear_redirect();

        // Reset state
        repeat (3) @(negedge clk);
        chk("rst req", 32'(imem_req), 32'd0);
        chk("rst valid", 32'(inst_valid), 32'd0);
        chk("rst fault", 32'(fault), 32'd0);
        chk("rst inst", inst, 32'h0);
        chk("rst addr", imem_addr, c_RESET_PC);

        rst_n = 1'b1;
        #1;
        chk("release req low", 32'(imem_req), 32'd0);
        @(negedge clk);
        chk("first req", 32'(imem_req), 32'd1);
        chk("first addr", imem_addr, c_RESET_PC);

        // Table-driven chain
        for (int i = 0; i < 16; i++) begin
            string tag;
            tag = $sformatf("v%0d", i);
            do_fetch(tag, vecs[i].exp_pc, vecs[i].word, vecs[i].gnt_wait, vecs[i].rv_wait);
            do_accept(tag, vecs[i]);
            chk({tag, " fault"}, 32'(fault), 32'd0);
        end

        // Misaligned jr target at pc 0x100
        do_fetch("mis", 32'h0000_0100, 32'h03E0_0008, 0, 0);
        jr = 1'b1; jr_target = 32'h0000_0083; inst_ready = 1'b1;
        @(negedge clk);
        inst_ready = 1'b0;
        clear_redirect();
`ifdef FETCH_ALIGN_CHECK_EN
        chk("mis fault", 32'(fault), 32'd1);
        chk("mis req", 32'(imem_req), 32'd0);
        chk("mis valid", 32'(inst_valid), 32'd0);
        chk("mis pc held", pc, 32'h0000_0100);
        repeat (3) @(negedge clk);
        chk("halt req", 32'(imem_req), 32'd0);
        chk("halt fault", 32'(fault), 32'd1);
        // Only reset recovers; bring the unit back to FETCH.
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk("post-halt fault", 32'(fault), 32'd0);
        chk("post-halt addr", imem_addr, c_RESET_PC);
`else
        chk("mis fault", 32'(fault), 32'd0);
        chk("mis next", imem_addr, 32'h0000_0080);
        chk("mis req", 32'(imem_req), 32'd1);
`endif

        // Reset while a request is outstanding (in WAIT)
        imem_gnt = 1'b1;
        @(negedge clk);
        imem_gnt = 1'b0;
        chk("rw in wait", 32'(imem_req), 32'd0);
        rst_n = 1'b0;
        #1;
        chk("rw async req", 32'(imem_req), 32'd0);
        chk("rw async addr", imem_addr, c_RESET_PC);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        imem_rvalid = 1'b1;      // late response, one cycle after release
        imem_rdata  = c_JUNK;
        @(negedge clk);
        imem_rvalid = 1'b0;
        chk("rw late valid", 32'(inst_valid), 32'd0);
        chk("rw late inst", inst, 32'h0);
        chk("rw addr", imem_addr, c_RESET_PC);
        chk("rw req", 32'(imem_req), 32'd1);

        // Normal operation resumes from RESET_PC
        do_fetch("rw", c_RESET_PC, 32'h2108_0002, 0, 0);
        do_accept("rw", mk(32'h2108_0002, 1'b0, 2'b00, 32'h0, 1'b0, 0, 0, 0,
                           32'h0000_0100, 32'h0000_0104, 32'h0000_0104));

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

`default_nettype wire
